// File: rtl/jk_ff_async.sv
// rtl/jk_ff_async.sv - WIDTH-bit bank of JK flip-flops with async reset (dominant) and async set
// Optional macro JK_FF_CHANGE_FLAG_EN adds q_chg, a registered per-bit flag for JK-induced changes.
module jk_ff_async #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
`ifdef JK_FF_CHANGE_FLAG_EN
  output logic [WIDTH-1:0] q_chg,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // JK characteristic equation: set when j and low, keep when high unless k.
  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  always_ff @(posedge clk or posedge rst or posedge set) begin
    if (rst) begin
      q_q <= '0;
    end else if (set) begin
      q_q <= '1;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign q_n = ~q_q;

`ifdef JK_FF_CHANGE_FLAG_EN
  logic [WIDTH-1:0] chg_q;
  logic [WIDTH-1:0] chg_d;

  always_comb begin
    chg_d = q_d ^ q_q;
  end

  // Async events clear the flag so forced values never look like JK changes.
  always_ff @(posedge clk or posedge rst or posedge set) begin
    if (rst) begin
      chg_q <= '0;
    end else if (set) begin
      chg_q <= '0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign q_chg = chg_q;
`else
`endif

endmodule

// File: tb/tb_jk_ff_async.sv
// tb/tb_jk_ff_async.sv - self-checking bench for jk_ff_async (WIDTH=1 and WIDTH=4 instances)
module tb_jk_ff_async;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       set = 1'b0;
  logic       j1 = 1'b0;
  logic       k1 = 1'b0;
  logic       q1;
  logic       qn1;
  logic [3:0] j4 = 4'b0000;
  logic [3:0] k4 = 4'b0000;
  logic [3:0] q4;
  logic [3:0] qn4;
`ifdef JK_FF_CHANGE_FLAG_EN
  logic       chg1;
  logic [3:0] chg4;
`endif

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  jk_ff_async #(.WIDTH(1)) u1 (
    .clk  (clk),
    .rst  (rst),
    .set  (set),
    .j    (j1),
    .k    (k1),
`ifdef JK_FF_CHANGE_FLAG_EN
    .q_chg(chg1),
`endif
    .q    (q1),
    .q_n  (qn1)
  );

  jk_ff_async #(.WIDTH(4)) u4 (
    .clk  (clk),
    .rst  (rst),
    .set  (set),
    .j    (j4),
    .k    (k4),
`ifdef JK_FF_CHANGE_FLAG_EN
    .q_chg(chg4),
`endif
    .q    (q4),
    .q_n  (qn4)
  );

  typedef struct {
    logic j;
    logic k;
    logic exp_q;
    logic exp_chg;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic exp_q);
    chk({name, "_q"}, {3'b000, q1}, {3'b000, exp_q});
    chk({name, "_qn"}, {3'b000, qn1}, {3'b000, ~exp_q});
  endtask

  task automatic chk4(input string name, input logic [3:0] exp_q);
    chk({name, "_q4"}, q4, exp_q);
    chk({name, "_qn4"}, qn4, ~exp_q);
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] m_q;
  logic [3:0] m_chg;
  logic [3:0] nxt;

  initial begin
    tbl[0] = '{j: 1'b0, k: 1'b0, exp_q: 1'b1, exp_chg: 1'b0};
    tbl[1] = '{j: 1'b0, k: 1'b1, exp_q: 1'b0, exp_chg: 1'b1};
    tbl[2] = '{j: 1'b1, k: 1'b0, exp_q: 1'b1, exp_chg: 1'b1};
    tbl[3] = '{j: 1'b1, k: 1'b1, exp_q: 1'b0, exp_chg: 1'b1};
    tbl[4] = '{j: 1'b1, k: 1'b1, exp_q: 1'b1, exp_chg: 1'b1};

    // Reset mid-cycle, before the first clock edge
    #5 rst = 1'b1;
    #1;
    chk1("rst_async", 1'b0);
    chk4("rst_async", 4'b0000);
`ifdef JK_FF_CHANGE_FLAG_EN
    chk("rst_chg", {3'b000, chg1}, 4'b0000);
`endif
    j1 = 1'b1;
    k1 = 1'b1;
    edge_sample();
    chk1("rst_hold_e1", 1'b0);
    edge_sample();
    chk1("rst_hold_e2", 1'b0);

    // Async set for 15 ns without relying on a clock edge
    @(negedge clk);
    rst = 1'b0;
    j1  = 1'b0;
    k1  = 1'b0;
    set = 1'b1;
    #2;
    chk1("set_async", 1'b1);
    chk4("set_async", 4'b1111);
    #13 set = 1'b0;
    #1;
    chk1("set_released_pre_edge", 1'b1);
    edge_sample();
    chk1("set_release_hold", 1'b1);
`ifdef JK_FF_CHANGE_FLAG_EN
    chk("set_release_chg", {3'b000, chg1}, 4'b0000);
`endif

    // JK truth table starting from q=1
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      j1 = tbl[i].j;
      k1 = tbl[i].k;
      #1;
      chk1($sformatf("jk_no_comb_path_%0d", i), (i == 0) ? 1'b1 : tbl[i-1].exp_q);
      edge_sample();
      chk1($sformatf("jk_tbl_%0d", i), tbl[i].exp_q);
`ifdef JK_FF_CHANGE_FLAG_EN
      chk($sformatf("jk_chg_%0d", i), {3'b000, chg1}, {3'b000, tbl[i].exp_chg});
`endif
    end

    // Simultaneous rst+set mid-cycle while toggling; reset must win
    @(negedge clk);
    j1 = 1'b1;
    k1 = 1'b1;
    #5;
    rst = 1'b1;
    set = 1'b1;
    #2;
    chk1("prio_both", 1'b0);
    chk4("prio_both", 4'b0000);
`ifdef JK_FF_CHANGE_FLAG_EN
    chk("prio_chg", {3'b000, chg1}, 4'b0000);
`endif
    edge_sample();
    chk1("prio_hold_edge", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    set = 1'b0;
    edge_sample();
    chk1("prio_resume_t1", 1'b1);
`ifdef JK_FF_CHANGE_FLAG_EN
    chk("prio_resume_chg", {3'b000, chg1}, 4'b0001);
`endif
    edge_sample();
    chk1("prio_resume_t2", 1'b0);

    // WIDTH=4 vector: set/clear/toggle/hold on separate bits
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk4("vec_reset", 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    j4  = 4'b1010;
    k4  = 4'b0110;
    edge_sample();
    chk4("vec_e1", 4'b1010);
`ifdef JK_FF_CHANGE_FLAG_EN
    chk("vec_chg_e1", chg4, 4'b1010);
`endif
    edge_sample();
    chk4("vec_e2", 4'b1000);
`ifdef JK_FF_CHANGE_FLAG_EN
    chk("vec_chg_e2", chg4, 4'b0010);
`endif

    // Random j/k/rst/set against a reference model
    m_q   = 4'b1000;
    m_chg = 4'b0010;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      j4  = 4'($urandom_range(0, 15));
      k4  = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 7) == 0);
      set = ($urandom_range(0, 5) == 0);
      #1;
      if (rst) begin
        chk4($sformatf("rnd_async_rst_%0d", c), 4'b0000);
      end
      edge_sample();
      if (rst) begin
        nxt   = 4'b0000;
        m_chg = 4'b0000;
      end else if (set) begin
        nxt   = 4'b1111;
        m_chg = 4'b0000;
      end else begin
        for (int b = 0; b < 4; b++) begin
          case ({j4[b], k4[b]})
            2'b00:   nxt[b] = m_q[b];
            2'b01:   nxt[b] = 1'b0;
            2'b10:   nxt[b] = 1'b1;
            default: nxt[b] = ~m_q[b];
          endcase
        end
        m_chg = nxt ^ m_q;
      end
      m_q = nxt;
      chk4($sformatf("rnd_%0d", c), m_q);
`ifdef JK_FF_CHANGE_FLAG_EN
      chk($sformatf("rnd_chg_%0d", c), chg4, m_chg);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
